// File: rtl/ahb_slave_mux.sv
`default_nettype none
// ============================================================================
// Module   : ahb_slave_mux
// Purpose  : AHB response mux with registered data-phase select and a
//            built-in default slave that counts its ERROR responses.
// Revision : 1.0 - initial release
// ============================================================================
module ahb_slave_mux #(
  parameter int SLAVE_DEVICES  = 4,
  parameter int AHB_DATA_WIDTH = 32,
  parameter int ERR_CNT_WIDTH  = 8
) (
  input  logic                                    ahb_clk_in,
  input  logic                                    ahb_rst_in,
  input  logic [1:0]                              ahb_trans_in,
  input  logic [SLAVE_DEVICES-1:0]                slave_sel_in,
  input  logic [SLAVE_DEVICES*AHB_DATA_WIDTH-1:0] slave_rdata_in,
  input  logic [SLAVE_DEVICES-1:0]                slave_ready_in,
  input  logic [SLAVE_DEVICES-1:0]                slave_resp_in,
  output logic [AHB_DATA_WIDTH-1:0]               ahb_rdata_out,
  output logic                                    ahb_ready_out,
  output logic                                    ahb_resp_out,
  output logic [SLAVE_DEVICES-1:0]                data_sel_out,
  output logic [ERR_CNT_WIDTH-1:0]                err_cnt_out
);

  localparam logic [1:0]               c_HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0]               c_HTRANS_SEQ    = 2'd3;
  localparam logic [ERR_CNT_WIDTH-1:0] c_ERR_CNT_MAX   = {ERR_CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_t;

  ds_state_t                r_state;
  ds_state_t                w_state_nxt;
  logic [SLAVE_DEVICES-1:0] r_data_sel;
  logic [SLAVE_DEVICES-1:0] w_data_sel_nxt;
  logic [ERR_CNT_WIDTH-1:0] r_err_cnt;
  logic [ERR_CNT_WIDTH-1:0] w_err_cnt_nxt;
  logic                     w_active;
  logic                     w_valid_sel;
  logic                     w_err_entry;

  assign w_active    = (ahb_trans_in == c_HTRANS_NONSEQ) || (ahb_trans_in == c_HTRANS_SEQ);
  assign w_valid_sel = $onehot(slave_sel_in);
  // The mux only samples the address phase when its own HREADY is high
  assign w_err_entry = ahb_ready_out && w_active && !w_valid_sel;

  always_ff @(posedge ahb_clk_in or posedge ahb_rst_in) begin
    if (ahb_rst_in) begin
      r_state    <= DS_IDLE;
      r_data_sel <= '0;
      r_err_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_data_sel <= w_data_sel_nxt;
      r_err_cnt  <= w_err_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_data_sel_nxt = r_data_sel;
    w_err_cnt_nxt  = r_err_cnt;
    if (r_state == DS_ERR1) begin
      w_state_nxt = DS_ERR2;
    end else if (ahb_ready_out) begin
      if (w_active && w_valid_sel) begin
        w_state_nxt    = DS_IDLE;
        w_data_sel_nxt = slave_sel_in;
      end else if (w_active) begin
        w_state_nxt    = DS_ERR1;
        w_data_sel_nxt = '0;
      end else begin
        w_state_nxt    = DS_IDLE;
        w_data_sel_nxt = '0;
      end
    end
    if (w_err_entry && (r_err_cnt != c_ERR_CNT_MAX)) begin
      w_err_cnt_nxt = r_err_cnt + ERR_CNT_WIDTH'(1);
    end
  end

  // Select is one-hot or zero, so an AND-OR mux is sufficient
  always_comb begin
    ahb_rdata_out = '0;
    ahb_ready_out = 1'b1;
    ahb_resp_out  = 1'b0;
    case (r_state)
      DS_ERR1: begin
        ahb_ready_out = 1'b0;
        ahb_resp_out  = 1'b1;
      end
      DS_ERR2: begin
        ahb_ready_out = 1'b1;
        ahb_resp_out  = 1'b1;
      end
      default: begin
        if (r_data_sel != '0) begin
          ahb_ready_out = 1'b0;
          for (int k = 0; k < SLAVE_DEVICES; k++) begin
            if (r_data_sel[k]) begin
              ahb_rdata_out = ahb_rdata_out | slave_rdata_in[k*AHB_DATA_WIDTH +: AHB_DATA_WIDTH];
              ahb_ready_out = ahb_ready_out | slave_ready_in[k];
              ahb_resp_out  = ahb_resp_out | slave_resp_in[k];
            end
          end
        end
      end
    endcase
  end

  assign data_sel_out = r_data_sel;
  assign err_cnt_out  = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ahb_slave_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_slave_mux
// Purpose  : Directed scoreboard bench for ahb_slave_mux.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_slave_mux;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int CW = 8;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] NONSEQ = 2'd2;
  localparam logic [1:0] SEQ    = 2'd3;

  logic            clk;
  logic            rst;
  logic [1:0]      trans;
  logic [N-1:0]    sel;
  logic [N*DW-1:0] srdata;
  logic [N-1:0]    sready;
  logic [N-1:0]    sresp;
  logic [DW-1:0]   rdata;
  logic            ready;
  logic            resp;
  logic [N-1:0]    dsel;
  logic [CW-1:0]   cnt;

  typedef struct {
    logic          ready;
    logic          resp;
    logic [DW-1:0] rdata;
    logic [N-1:0]  dsel;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_assert;
  int   n_fail;

  ahb_slave_mux #(
    .SLAVE_DEVICES (N),
    .AHB_DATA_WIDTH(DW),
    .ERR_CNT_WIDTH (CW)
  ) dut (
    .ahb_clk_in    (clk),
    .ahb_rst_in    (rst),
    .ahb_trans_in  (trans),
    .slave_sel_in  (sel),
    .slave_rdata_in(srdata),
    .slave_ready_in(sready),
    .slave_resp_in (sresp),
    .ahb_rdata_out (rdata),
    .ahb_ready_out (ready),
    .ahb_resp_out  (resp),
    .data_sel_out  (dsel),
    .err_cnt_out   (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input string field, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp);
    end
  endtask

  task automatic push(input logic er, input logic es, input logic [DW-1:0] ed,
                      input logic [N-1:0] eds, input logic [CW-1:0] ec);
    exp_t e;
    e.ready = er; e.resp = es; e.rdata = ed; e.dsel = eds; e.cnt = ec;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
    end else begin
      e = sb.pop_front();
      chk(tag, "ready", DW'(ready), DW'(e.ready));
      chk(tag, "resp",  DW'(resp),  DW'(e.resp));
      chk(tag, "rdata", rdata,      e.rdata);
      chk(tag, "dsel",  DW'(dsel),  DW'(e.dsel));
      chk(tag, "cnt",   DW'(cnt),   DW'(e.cnt));
    end
  endtask

  task automatic drive(input logic [1:0] t, input logic [N-1:0] s,
                       input logic [N-1:0] rdy, input logic [N-1:0] rsp);
    trans = t; sel = s; sready = rdy; sresp = rsp;
  endtask

  // One bus cycle: drive at the falling edge, check the data-phase outputs of this cycle
  task automatic cyc(input string tag, input logic [1:0] t, input logic [N-1:0] s,
                     input logic [N-1:0] rdy, input logic [N-1:0] rsp,
                     input logic er, input logic es, input logic [DW-1:0] ed,
                     input logic [N-1:0] eds, input logic [CW-1:0] ec);
    drive(t, s, rdy, rsp);
    push(er, es, ed, eds, ec);
    #1;
    pop_check(tag);
    @(negedge clk);
  endtask

  function automatic logic [DW-1:0] sdat(input int k);
    return 32'hA5A5_0000 | DW'(k);
  endfunction

  initial begin
    logic [CW-1:0] ec;
    n_assert = 0;
    n_fail   = 0;
    for (int k = 0; k < N; k++) srdata[k*DW +: DW] = sdat(k);
    rst = 1'b1;
    drive(IDLE, '0, '1, '0);
    push(1'b1, 1'b0, '0, '0, '0);
    #1;
    pop_check("reset");
    @(negedge clk);
    rst = 1'b0;

    // simple read from slave 1
    cyc("rd_addr",  NONSEQ, 4'b0010, 4'b1111, 4'b0000, 1, 0, '0,      4'b0000, 0);
    cyc("rd_data",  IDLE,   4'b0000, 4'b1111, 4'b0000, 1, 0, sdat(1), 4'b0010, 0);

    // slave 2 with three wait states; address changes meanwhile are ignored
    cyc("ws_addr",  NONSEQ, 4'b0100, 4'b1111, 4'b0000, 1, 0, '0,      4'b0000, 0);
    cyc("ws_w1",    NONSEQ, 4'b0001, 4'b1011, 4'b0000, 0, 0, sdat(2), 4'b0100, 0);
    cyc("ws_w2",    NONSEQ, 4'b0001, 4'b1011, 4'b0000, 0, 0, sdat(2), 4'b0100, 0);
    cyc("ws_w3",    SEQ,    4'b0001, 4'b1011, 4'b0000, 0, 0, sdat(2), 4'b0100, 0);
    cyc("ws_data",  IDLE,   4'b0000, 4'b1111, 4'b0000, 1, 0, sdat(2), 4'b0100, 0);

    // default slave, then back-to-back multi-hot error
    cyc("ds_addr",  NONSEQ, 4'b0000, 4'b1111, 4'b0000, 1, 0, '0, 4'b0000, 0);
    cyc("ds_err1",  IDLE,   4'b0000, 4'b1111, 4'b0000, 0, 1, '0, 4'b0000, 1);
    cyc("mh_err2",  NONSEQ, 4'b0011, 4'b1111, 4'b0000, 1, 1, '0, 4'b0000, 1);
    cyc("mh_err1",  SEQ,    4'b0011, 4'b1111, 4'b0000, 0, 1, '0, 4'b0000, 2);
    cyc("mh_err2b", IDLE,   4'b0000, 4'b1111, 4'b0000, 1, 1, '0, 4'b0000, 2);

    // IDLE/BUSY with zero select: zero-wait OKAY, nothing counted
    cyc("idle0",    BUSY,   4'b0000, 4'b1111, 4'b0000, 1, 0, '0, 4'b0000, 2);
    cyc("busy0",    IDLE,   4'b0000, 4'b1111, 4'b0000, 1, 0, '0, 4'b0000, 2);

    // slave 3 ERROR passed through, not counted
    cyc("se_addr",  NONSEQ, 4'b1000, 4'b1111, 4'b0000, 1, 0, '0,      4'b0000, 2);
    cyc("se_data",  IDLE,   4'b0000, 4'b1111, 4'b1000, 1, 1, sdat(3), 4'b1000, 2);
    cyc("se_after", IDLE,   4'b0000, 4'b1111, 4'b0000, 1, 0, '0,      4'b0000, 2);

    // 300 back-to-back errors: counter saturates
    cyc("sat_addr", NONSEQ, 4'b0000, 4'b1111, 4'b0000, 1, 0, '0, 4'b0000, 2);
    for (int i = 0; i < 300; i++) begin
      ec = (3 + i > 255) ? 8'd255 : CW'(3 + i);
      cyc("sat_e1", NONSEQ, 4'b0000, 4'b1111, 4'b0000, 0, 1, '0, 4'b0000, ec);
      cyc("sat_e2", NONSEQ, 4'b0000, 4'b1111, 4'b0000, 1, 1, '0, 4'b0000, ec);
    end
    cyc("sat_t1",   IDLE,   4'b0000, 4'b1111, 4'b0000, 0, 1, '0, 4'b0000, 8'd255);
    cyc("sat_t2",   IDLE,   4'b0000, 4'b1111, 4'b0000, 1, 1, '0, 4'b0000, 8'd255);
    cyc("sat_idle", IDLE,   4'b0000, 4'b1111, 4'b0000, 1, 0, '0, 4'b0000, 8'd255);

    // asynchronous reset while in ERR1
    cyc("mr_addr",  NONSEQ, 4'b0000, 4'b1111, 4'b0000, 1, 0, '0, 4'b0000, 8'd255);
    drive(IDLE, 4'b0000, 4'b1111, 4'b0000);
    push(1'b0, 1'b1, '0, '0, 8'd255);
    #1;
    pop_check("mr_err1");
    #1 rst = 1'b1;
    push(1'b1, 1'b0, '0, '0, '0);
    #1;
    pop_check("mr_rst_err");
    @(negedge clk);
    rst = 1'b0;

    // asynchronous reset during a slave wait state
    cyc("mw_addr",  NONSEQ, 4'b0100, 4'b1111, 4'b0000, 1, 0, '0, 4'b0000, 0);
    drive(IDLE, 4'b0000, 4'b1011, 4'b0000);
    push(1'b0, 1'b0, sdat(2), 4'b0100, '0);
    #1;
    pop_check("mw_wait");
    #1 rst = 1'b1;
    push(1'b1, 1'b0, '0, '0, '0);
    #1;
    pop_check("mw_rst_wait");
    @(negedge clk);
    rst = 1'b0;
    cyc("mw_after", IDLE,   4'b0000, 4'b1011, 4'b0000, 1, 0, '0, 4'b0000, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
